// File: rtl/data_path.sv
// data_path: 32-bit single-bus CPU datapath (16 GPRs, PC, IR, MAR, MDR, HI, LO, Y, Z, ports, ALU).
// Define ZERO_R0_EN to hardwire R0 to zero on the bus and ignore R0in.
module data_path (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Gra, Grb, Grc,
  input  logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        Zin_high, Zin_low, IncPC, Read, Write,
  input  logic        outPortenable, inPortenable,
  input  logic [31:0] Mdatain,
  input  logic [31:0] inPort_input,
  input  logic [3:0]  operation,
  output logic [31:0] outport_out
);
  logic [31:0] r [16];
  logic [31:0] r_val [16];
  logic [31:0] pc, ir, mar, mdr, hi, lo, y, in_port, out_port, bus, c_ext, sra;
  logic signed [31:0] sq, sr;
  logic [63:0] z, alu_res, rot_r, rot_l, prod;
  logic [15:0] r_out, r_in, r_ld;
  logic [3:0] gr_sel;
  logic [4:0] sh;
  logic div0, unused;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

`ifdef ZERO_R0_EN
  always_comb begin
    r_val = r;
    r_val[0] = '0;
  end
  assign r_ld = {r_in[15:1], 1'b0};
`else
  always_comb r_val = r;
  assign r_ld = r_in;
`endif

  assign gr_sel = Gra ? ir[26:23] : Grb ? ir[22:19] : ir[18:15];
  assign c_ext = {{13{ir[18]}}, ir[18:0]};

  // Lowest priority first so later drivers win.
  always_comb begin
    bus = '0;
    if (Gra | Grb | Grc) bus = r_val[gr_sel];
    if (Cout) bus = c_ext;
    if (In_Portout) bus = in_port;
    if (MDRout) bus = mdr;
    if (PCout) bus = pc;
    if (Zlowout) bus = z[31:0];
    if (Zhighout) bus = z[63:32];
    if (LOout) bus = lo;
    if (HIout) bus = hi;
    for (int i = 15; i >= 0; i--) if (r_out[i]) bus = r_val[i];
  end

  assign sh = bus[4:0];
  assign rot_r = {y, y} >> sh;
  assign rot_l = {y, y} << sh;
  assign sra = $signed(y) >>> sh;
  assign prod = {{32{y[31]}}, y} * {{32{bus[31]}}, bus};
  assign div0 = bus == '0;
  assign sq = $signed(y) / $signed(bus);
  assign sr = $signed(y) % $signed(bus);

  always_comb begin
    alu_res = {32'b0, bus};
    case (operation)
      4'd0: alu_res[31:0] = y + bus;
      4'd1: alu_res[31:0] = y - bus;
      4'd2: alu_res[31:0] = y >> sh;
      4'd3: alu_res[31:0] = sra;
      4'd4: alu_res[31:0] = y << sh;
      4'd5: alu_res[31:0] = rot_r[31:0];
      4'd6: alu_res[31:0] = rot_l[63:32];
      4'd7: alu_res[31:0] = y | bus;
      4'd8: alu_res[31:0] = y & bus;
      4'd9: alu_res = prod;
      4'd10: alu_res = div0 ? {y, 32'hFFFF_FFFF} : {sr, sq};
      4'd11: alu_res[31:0] = -bus;
      4'd12: alu_res[31:0] = ~bus;
      default: ;
    endcase
    if (IncPC) alu_res = {32'b0, bus + 32'd1};
  end

  always_ff @(posedge Clock or posedge clear)
    if (clear) begin
      r <= '{default: '0};
      pc <= '0;
      ir <= '0;
      mar <= '0;
      mdr <= '0;
      hi <= '0;
      lo <= '0;
      y <= '0;
      z <= '0;
      in_port <= '0;
      out_port <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (r_ld[i]) r[i] <= bus;
      if (PCin) pc <= bus;
      if (IRin) ir <= bus;
      if (MARin) mar <= bus;
      if (MDRin) mdr <= Read ? Mdatain : bus;
      if (HIin) hi <= bus;
      if (LOin) lo <= bus;
      if (Yin) y <= bus;
      if (Zin_high) z[63:32] <= alu_res[63:32];
      if (Zin_low) z[31:0] <= alu_res[31:0];
      if (inPortenable) in_port <= inPort_input;
      if (outPortenable) out_port <= bus;
    end

  assign outport_out = out_port;
  assign unused = ^{Write, ir[31:27], mar};
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: scoreboard bench; values routed to the out-port are queued and compared on the following negedge.
module tb_data_path;
  logic Clock = 0, clear = 0;
  logic Gra, Grb, Grc, PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout;
  logic [15:0] rout, rin;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_high, Zin_low, IncPC, Read, Write;
  logic outPortenable, inPortenable;
  logic [31:0] Mdatain = 0, inPort_input = 0, outport_out;
  logic [3:0] operation;
  int errors = 0, checks = 0;
  logic obs = 0, due = 0;
  string tq[$];
  logic [31:0] eq[$];

  data_path dut (
    .Clock(Clock), .clear(clear), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .In_Portout(In_Portout), .Cout(Cout),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .Zin_high(Zin_high), .Zin_low(Zin_low), .IncPC(IncPC), .Read(Read), .Write(Write),
    .outPortenable(outPortenable), .inPortenable(inPortenable),
    .Mdatain(Mdatain), .inPort_input(inPort_input), .operation(operation),
    .outport_out(outport_out)
  );

  always #5 Clock = ~Clock;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge Clock) due <= obs;
  always @(negedge Clock) if (due && eq.size() > 0) check(tq.pop_front(), outport_out, eq.pop_front());

  task automatic idle();
    {Gra, Grb, Grc, PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout} = '0;
    {MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_high, Zin_low, IncPC, Read, Write} = '0;
    {outPortenable, inPortenable, obs} = '0;
    rout = '0;
    rin = '0;
    operation = '0;
  endtask

  task automatic cycle();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic show(string tag, logic [31:0] exp);
    outPortenable = 1;
    obs = 1;
    tq.push_back(tag);
    eq.push_back(exp);
    cycle();
  endtask

  task automatic mem_to_mdr(logic [31:0] v);
    Mdatain = v;
    Read = 1;
    MDRin = 1;
    cycle();
  endtask

  task automatic load_reg(int i, logic [31:0] v);
    mem_to_mdr(v);
    MDRout = 1;
    rin[i] = 1;
    cycle();
  endtask

  task automatic show_reg(string tag, int i, logic [31:0] v);
    rout[i] = 1;
    show(tag, v);
  endtask

  task automatic set_y(logic [31:0] v);
    mem_to_mdr(v);
    MDRout = 1;
    Yin = 1;
    cycle();
  endtask

  task automatic alu(logic [3:0] op, logic [31:0] b);
    mem_to_mdr(b);
    MDRout = 1;
    operation = op;
    Zin_high = 1;
    Zin_low = 1;
    cycle();
  endtask

  task automatic show_zlo(string tag, logic [31:0] v);
    Zlowout = 1;
    show(tag, v);
  endtask

  task automatic show_zhi(string tag, logic [31:0] v);
    Zhighout = 1;
    show(tag, v);
  endtask

  task automatic alu_case(string tag, logic [31:0] a, logic [3:0] op, logic [31:0] b, logic [31:0] exp);
    set_y(a);
    alu(op, b);
    show_zlo(tag, exp);
  endtask

  initial begin
    logic [31:0] a, b;
    idle();
    clear = 1;
    #12;
    check("por_out", outport_out, 0);
    clear = 0;
    load_reg(1, 32'h55);
    mem_to_mdr(32'h77);
    MDRout = 1;
    PCin = 1;
    cycle();
    show_reg("pre_r1", 1, 32'h55);
    @(negedge Clock);
    #1 clear = 1;
    #1;
    check("rst_out", outport_out, 0);
    check("rst_r1", dut.r[1], 0);
    check("rst_pc", dut.pc, 0);
    check("rst_mdr", dut.mdr, 0);
    #1 clear = 0;
    show_reg("post_rst_r1", 1, 0);

    load_reg(2, 12);
    load_reg(3, 14);
    load_reg(1, 18);
    show_reg("r2", 2, 12);
    show_reg("r3", 3, 14);
    show_reg("r1", 1, 18);

    PCout = 1; MARin = 1; IncPC = 1; Zin_low = 1;
    cycle();
    check("t0_mar", dut.mar, 0);
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h2891_8000;
    cycle();
    MDRout = 1; IRin = 1;
    cycle();
    rout[2] = 1; Yin = 1;
    cycle();
    rout[3] = 1; operation = 4'b1000; Zin_low = 1;
    cycle();
    show_zlo("t4_zlo", 12);
    Zlowout = 1; rin[1] = 1;
    cycle();
    show_reg("and_r1", 1, 12);
    PCout = 1;
    show("and_pc", 1);

    load_reg(1, 18);
    Gra = 1; MARin = 1;
    cycle();
    check("gra_mar", dut.mar, 18);
    Gra = 1; Grb = 1;
    show("gra_prio", 18);
    Grb = 1; Grc = 1;
    show("grb_prio", 12);
    Grc = 1;
    show("grc", 14);

    rout[2] = 1; rout[3] = 1; PCout = 1;
    show("bus_prio", 12);
    show("bus_none", 0);

    set_y(32'hFFFF_FFFD);
    alu(4'd9, 7);
    show_zlo("mul_lo", 32'hFFFF_FFEB);
    show_zhi("mul_hi", 32'hFFFF_FFFF);
    set_y(14);
    alu(4'd10, 0);
    show_zlo("div0_q", 32'hFFFF_FFFF);
    show_zhi("div0_r", 14);
    set_y(100);
    alu(4'd10, 7);
    show_zlo("div_q", 14);
    show_zhi("div_r", 2);

    inPort_input = 32'hA5A5;
    inPortenable = 1;
    cycle();
    inPort_input = 32'h1111;
    In_Portout = 1;
    show("inport", 32'hA5A5);

    alu_case("ror", 32'h8000_0001, 4'd5, 1, 32'hC000_0000);
    show_zhi("ror_hi", 0);
    alu_case("rol", 32'h8000_0001, 4'd6, 1, 32'h0000_0003);
    alu_case("shra", 32'h8000_0000, 4'd3, 4, 32'hF800_0000);
    alu_case("shr", 32'h8000_0000, 4'd2, 4, 32'h0800_0000);
    alu_case("shl_mod32", 32'h1, 4'd4, 33, 32'h2);
    alu_case("or", 32'hF0, 4'd7, 32'h0F, 32'hFF);
    alu_case("neg", 32'h9, 4'd11, 5, 32'hFFFF_FFFB);
    alu_case("not", 32'h9, 4'd12, 0, 32'hFFFF_FFFF);
    alu_case("pass", 32'h9, 4'd15, 32'h1234, 32'h1234);
    set_y(32'h40);
    mem_to_mdr(32'hFFFF_FFFF);
    MDRout = 1; operation = 4'd1; IncPC = 1; Zin_low = 1; Zin_high = 1;
    cycle();
    show_zlo("incpc_wrap", 0);
    for (int k = 0; k < 3; k++) begin
      a = $urandom;
      b = $urandom;
      alu_case("add_rnd", a, 4'd0, b, a + b);
      alu_case("sub_rnd", a, 4'd1, b, a - b);
    end

    mem_to_mdr(32'h0007_FFFF);
    MDRout = 1; IRin = 1;
    cycle();
    Cout = 1;
    show("c_neg", 32'hFFFF_FFFF);
    Cout = 1; Yin = 1;
    cycle();
    alu(4'd0, 0);
    show_zlo("c_to_y", 32'hFFFF_FFFF);
    mem_to_mdr(32'hF803_FFFF);
    MDRout = 1; IRin = 1;
    cycle();
    Cout = 1;
    show("c_pos", 32'h0003_FFFF);

    repeat (4) @(negedge Clock);
    check("sb_drain", 32'(eq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_path.md
Name:
data_path

Overview:
- 32-bit single-bus CPU datapath: 16 GPRs, PC, IR, MAR, MDR, HI, LO, Y, 64-bit Z, in-port, out-port, a combinational ALU and a bus multiplexer.
- An external control unit (or bench) sequences it cycle by cycle using one-hot "out" (bus drive) and "in" (register load) strobes.
- Memory is external; read data enters through Mdatain.

Parameters:
- none (word width fixed at 32, register count fixed at 16)

Ports:
- Clock  in  1  system clock; all loads occur on the rising edge.
- clear  in  1  asynchronous active-high reset.
- Gra, Grb, Grc  in  1 each  drive GPR selected by IR field ra/rb/rc onto the bus.
- PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout  in  1 each  bus drive strobes.
- R0out..R15out  in  1 each  GPR bus drive strobes.
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin  in  1 each  load from bus.
- R0in..R15in  in  1 each  GPR load from bus.
- Zin_high, Zin_low  in  1 each  load Z[63:32] / Z[31:0] from ALU result.
- IncPC  in  1  ALU computes bus+1, overriding operation.
- Read  in  1  MDR input mux selects Mdatain (else bus).
- Write  in  1  memory write strobe; reserved, no internal effect.
- outPortenable  in  1  load out-port register from bus.
- inPortenable  in  1  load in-port register from inPort_input.
- Mdatain  in  32  memory read data.
- inPort_input  in  32  external input-port data.
- operation  in  4  ALU opcode.
- outport_out  out  32  out-port register contents.

Behaviour:
- Reset: clear=1 asynchronously zeroes every register (GPRs, PC, IR, MAR, MDR, HI, LO, Y, Z, in-port, out-port); outport_out=0.
- Loads: register updates on the posedge Clock when its in-strobe is 1; otherwise it holds. No other latency.
- Bus: combinational. Exactly one driver is expected. If several are asserted, fixed priority applies: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C, Gra/Grb/Grc. If none is asserted, bus=0.
- IR fields:
  - op = IR[31:27]
  - ra = IR[26:23]
  - rb = IR[22:19]
  - rc = IR[18:15]
  - C = sign-extend IR[18:0] to 32 bits (driven by Cout).
- Gr select priority: Gra > Grb > Grc.
- MDR: next = Read ? Mdatain : bus, loaded when MDRin=1.
- ALU operands and result: A=Y, B=bus. The 64-bit result R is loaded into Z halves independently by Zin_high/Zin_low. R[63:32]=0 unless stated otherwise.
- ALU opcodes:
  - 0000 ADD A+B
  - 0001 SUB A-B
  - 0010 SHR A>>B[4:0]
  - 0011 SHRA arithmetic
  - 0100 SHL
  - 0101 ROR
  - 0110 ROL
  - 0111 OR
  - 1000 AND
  - 1001 MUL: signed 64-bit product
  - 1010 DIV: signed; R[31:0]=quotient, R[63:32]=remainder. If B=0: quotient=FFFFFFFF, remainder=A.
  - 1011 NEG -B
  - 1100 NOT ~B
  - 1101-1111 pass B
- IncPC=1: R = {32'b0, B+1}, regardless of operation.
- Arithmetic: 32-bit wrap, no flags.
- Simultaneous events: a register may drive the bus and load in the same cycle; it loads the pre-edge bus value.
- Reset mid-operation: clear wins immediately, regardless of strobes.

Optional Feature:
- ZERO_R0_EN defined: R0 always reads 0 on the bus and ignores R0in.
- Undefined: R0 is an ordinary register.

Test Plan:
- Reset: load values into R1, PC and out-port, pulse clear asynchronously between edges -> all registers and outport_out read 0 immediately.
- Register loads via MDR:
  - Mdatain=12, Read+MDRin, then MDRout+R2in -> R2=12.
  - Likewise R3=14 and R1=18.
- AND R1,R2,R3, with PC=0:
  - T0: PCout, MARin, IncPC, Zin_low -> MAR=0, Zlow=1.
  - T1: Zlowout, PCin, Read, MDRin with Mdatain=28918000h -> PC=1.
  - T2: MDRout, IRin.
  - T3: R2out, Yin.
  - T4: R3out, operation=1000, Zin_low -> Zlow=12.
  - T5: Zlowout, R1in -> R1=12.
- MUL/DIV:
  - Y=-3, bus=7, op 1001, Zin_high+Zin_low -> Z=FFFFFFFF_FFFFFFEB.
  - DIV 14/0 -> Zlow=FFFFFFFF, Zhigh=14.
- Ports and Gr select:
  - inPort_input=A5A5h, inPortenable, then In_Portout+outPortenable -> outport_out=A5A5h.
  - With IR ra=1 and R1=18, Gra+MARin -> MAR=18.
- Shifts and C:
  - Y=80000001h, bus=1, op ROR -> Zlow=C0000000h.
  - IR[18:0]=7FFFFh with Cout+Yin -> Y=FFFFFFFFh.
